// File: rtl/cmt_job_ctrl_if.sv
// Host/FIFO/pipeline handshake bundle for the CMT job controller.
// The master modport is the environment side and the slave modport is the controller side.
interface cmt_job_ctrl_if #(
    parameter int unsigned JOBW = 8
);
    logic            start;
    logic [JOBW-1:0] num_jobs;
    logic            abort;
    logic            in_empty;
    logic            in_rd_en;
    logic            in_vld;
    logic            out_full;
    logic            res_vld;
    logic            shim_clr;
    logic [1:0]      phase;
    logic            busy;
    logic            job_done;
    logic            batch_done;
    logic            err;

    modport master (
        output start, num_jobs, abort, in_empty, out_full, res_vld,
        input  in_rd_en, in_vld, shim_clr, phase, busy, job_done, batch_done, err
    );

    modport slave (
        input  start, num_jobs, abort, in_empty, out_full, res_vld,
        output in_rd_en, in_vld, shim_clr, phase, busy, job_done, batch_done, err
    );
endinterface

// File: rtl/cmt_job_ctrl.sv
// Sequences batches of CMT jobs: per job it reads N*N kernel words and then N*N*N ternix words,
// waits for RESULTS pipeline results with an idle timeout, and then reports done or error.
module cmt_job_ctrl #(
    parameter int unsigned N       = 4,
    parameter int unsigned RESULTS = N * N * N,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned JOBW    = 8
) (
    input logic           clk,
    input logic           rst,
    cmt_job_ctrl_if.slave ctrl_io
);

    localparam int unsigned KernWords = N * N;
    localparam int unsigned TotWords  = N * N + N * N * N;
    localparam int unsigned RdCntW    = $clog2(TotWords) + 1;
    localparam int unsigned ResCntW   = $clog2(RESULTS) + 1;
    localparam int unsigned IdleCntW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StKernel,
        StTernix,
        StDrain,
        StDone,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic [RdCntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ResCntW-1:0]  res_cnt_q, res_cnt_d;
    logic [IdleCntW-1:0] idle_cnt_q, idle_cnt_d;
    logic [JOBW-1:0]     jobs_left_q, jobs_left_d;
    logic                in_vld_q;
    logic [1:0]          vld_phase_q;

    logic       rd_en;
    logic       rd_ok;
    logic       res_cnt_en;
    logic       shim_clr;
    logic       job_done;
    logic       batch_done;
    logic [1:0] cur_phase;

    // A read may be issued only while words remain and neither side is stalling this cycle.
    assign rd_ok = !ctrl_io.in_empty && !ctrl_io.out_full && (rd_cnt_q < RdCntW'(TotWords));

    // Results past RESULTS are dropped so they never leak into the next job.
    assign res_cnt_en = ctrl_io.res_vld && (res_cnt_q < ResCntW'(RESULTS));

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        res_cnt_d   = res_cnt_q;
        idle_cnt_d  = '0;
        jobs_left_d = jobs_left_q;
        rd_en       = 1'b0;
        shim_clr    = 1'b0;
        job_done    = 1'b0;
        batch_done  = 1'b0;

        unique case (state_q)
            StIdle, StErr: begin
                if (ctrl_io.start) begin
                    state_d     = StClear;
                    jobs_left_d = (ctrl_io.num_jobs == '0) ? JOBW'(1) : ctrl_io.num_jobs;
                end
            end
            StClear: begin
                shim_clr  = 1'b1;
                rd_cnt_d  = '0;
                res_cnt_d = '0;
                state_d   = StKernel;
            end
            StKernel: begin
                rd_en = rd_ok;
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + RdCntW'(1);
                    if (rd_cnt_q == RdCntW'(KernWords - 1)) begin
                        state_d = StTernix;
                    end
                end
                if (res_cnt_en) begin
                    res_cnt_d = res_cnt_q + ResCntW'(1);
                end
            end
            StTernix: begin
                rd_en = rd_ok;
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + RdCntW'(1);
                    if (rd_cnt_q == RdCntW'(TotWords - 1)) begin
                        state_d = StDrain;
                    end
                end
                if (res_cnt_en) begin
                    res_cnt_d = res_cnt_q + ResCntW'(1);
                end
            end
            StDrain: begin
                if (res_cnt_en) begin
                    res_cnt_d = res_cnt_q + ResCntW'(1);
                end
                if (!ctrl_io.res_vld) begin
                    idle_cnt_d = idle_cnt_q + IdleCntW'(1);
                end
                if (res_cnt_d == ResCntW'(RESULTS)) begin
                    state_d = StDone;
                end else if (idle_cnt_d == IdleCntW'(TIMEOUT)) begin
                    state_d = StErr;
                end
            end
            StDone: begin
                job_done    = 1'b1;
                jobs_left_d = jobs_left_q - JOBW'(1);
                if (jobs_left_q == JOBW'(1)) begin
                    batch_done = 1'b1;
                    state_d    = StIdle;
                end else begin
                    state_d = StClear;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a simultaneous start.
        if (ctrl_io.abort) begin
            state_d     = StIdle;
            shim_clr    = 1'b1;
            rd_en       = 1'b0;
            job_done    = 1'b0;
            batch_done  = 1'b0;
            rd_cnt_d    = '0;
            res_cnt_d   = '0;
            idle_cnt_d  = '0;
            jobs_left_d = '0;
        end
    end

    always_comb begin
        cur_phase = 2'd0;
        unique case (state_q)
            StKernel:        cur_phase = 2'd1;
            StTernix:        cur_phase = 2'd2;
            StDrain, StDone: cur_phase = 2'd3;
            default:         cur_phase = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_cnt_q    <= '0;
            res_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            jobs_left_q <= '0;
            in_vld_q    <= 1'b0;
            vld_phase_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            res_cnt_q   <= res_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            jobs_left_q <= jobs_left_d;
            in_vld_q    <= rd_en;
            vld_phase_q <= cur_phase;
        end
    end

    assign ctrl_io.in_rd_en   = rd_en;
    assign ctrl_io.in_vld     = in_vld_q;
    assign ctrl_io.shim_clr   = shim_clr;
    // While a word is landing, phase names the state that issued its read.
    assign ctrl_io.phase      = in_vld_q ? vld_phase_q : cur_phase;
    assign ctrl_io.busy       = (state_q != StIdle) && (state_q != StErr);
    assign ctrl_io.job_done   = job_done;
    assign ctrl_io.batch_done = batch_done;
    assign ctrl_io.err        = (state_q == StErr);

endmodule

// File: tb/tb_cmt_job_ctrl.sv
// Randomized self-checking bench for cmt_job_ctrl with N=2 and TIMEOUT=16.
module tb_cmt_job_ctrl;

    localparam int unsigned N     = 2;
    localparam int unsigned KW    = N * N;
    localparam int unsigned JW    = KW + N * N * N;
    localparam int unsigned RES   = N * N * N;
    localparam int unsigned TOUT  = 16;
    localparam int          BUDGET = 2000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cmt_job_ctrl_if #(.JOBW(8)) bus ();

    cmt_job_ctrl #(
        .N      (N),
        .RESULTS(RES),
        .TIMEOUT(TOUT),
        .JOBW   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Statistics gathered by run_batch from observed behaviour only.
    int n_reads, n_clr, n_jdone, n_bdone, n_viol, n_vld_bad, n_phase_bad, n_over, n_orphan;
    int first_rd, last_rd, last_res, err_cyc, stall_reads, cyc;
    bit ended, saw_err;

    task automatic run_batch(input int jobs, input int pe, input int pf, input int quota,
                             input int stall_at, input bit poke_start);
        int  job_reads, job_res, stall_cnt;
        bit  stall_done, prev_rd, in_stall;
        int  prev_ph;
        n_reads = 0; n_clr = 0; n_jdone = 0; n_bdone = 0; n_viol = 0; n_vld_bad = 0;
        n_phase_bad = 0; n_over = 0; n_orphan = 0; first_rd = -1; last_rd = -1;
        last_res = -1; err_cyc = -1; stall_reads = 0; cyc = 0; ended = 0; saw_err = 0;
        job_reads = 0; job_res = 0; stall_cnt = 0; stall_done = 0; prev_rd = 0; prev_ph = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_jobs = 8'(jobs);
        @(negedge clk);
        bus.start = 1'b0;
        while (!ended && cyc < BUDGET) begin
            if (cyc != 0) @(negedge clk);
            in_stall = (stall_cnt > 0);
            bus.in_empty = ($urandom_range(99) < pe);
            bus.out_full = in_stall ? 1'b1 : ($urandom_range(99) < pf);
            if (in_stall) stall_cnt--;
            bus.res_vld = (job_reads > KW) && (job_res < quota) && ($urandom_range(1) == 1);
            bus.start = poke_start && (cyc == 10);
            bus.num_jobs = bus.start ? 8'd5 : 8'(jobs);
            #1;
            cyc++;
            if (bus.shim_clr) begin
                n_clr++;
                job_reads = 0;
                job_res = 0;
            end
            if (bus.in_vld !== prev_rd) n_vld_bad++;
            if (bus.in_vld && bus.phase !== 2'(prev_ph)) n_phase_bad++;
            prev_rd = bus.in_rd_en;
            if (bus.in_rd_en) begin
                if (bus.in_empty || bus.out_full) n_viol++;
                if (in_stall) stall_reads++;
                prev_ph = (job_reads < KW) ? 1 : 2;
                n_reads++;
                job_reads++;
                if (job_reads > JW) n_over++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (bus.res_vld) begin
                job_res++;
                last_res = cyc;
            end
            if (bus.job_done) n_jdone++;
            if (bus.batch_done) begin
                n_bdone++;
                if (!bus.job_done) n_orphan++;
                ended = 1;
            end
            if (bus.err) begin
                saw_err = 1;
                err_cyc = cyc;
                ended = 1;
            end
            if (stall_at > 0 && job_reads == stall_at && !stall_done) begin
                stall_done = 1;
                stall_cnt = 5;
            end
        end
        bus.in_empty = 1'b0;
        bus.out_full = 1'b0;
        bus.res_vld = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (!ended) begin
            errors++;
            $display("FAIL batch_timeout: no batch_done/err after %0d cycles, required end", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        checks++;
        if ({bus.in_rd_en, bus.in_vld, bus.shim_clr, bus.phase, bus.busy, bus.job_done,
             bus.batch_done, bus.err} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {bus.in_rd_en, bus.in_vld,
                     bus.shim_clr, bus.phase, bus.busy, bus.job_done, bus.batch_done, bus.err});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.phase !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b phase=%0d required 0/0", bus.busy, bus.phase);
        end
    endtask

    task automatic check_common(input string name, input int jobs);
        checks++;
        if (n_reads != jobs * JW) begin
            errors++;
            $display("FAIL %s_reads: got %0d required %0d", name, n_reads, jobs * JW);
        end
        checks++;
        if (n_jdone != jobs || n_bdone != 1 || n_orphan != 0) begin
            errors++;
            $display("FAIL %s_done: job_done=%0d batch_done=%0d orphan=%0d required %0d/1/0",
                     name, n_jdone, n_bdone, n_orphan, jobs);
        end
        checks++;
        if (n_clr != jobs) begin
            errors++;
            $display("FAIL %s_shim_clr: got %0d required %0d", name, n_clr, jobs);
        end
        checks++;
        if (n_viol != 0 || n_vld_bad != 0 || n_over != 0 || n_phase_bad != 0) begin
            errors++;
            $display("FAIL %s_protocol: viol=%0d vld=%0d over=%0d phase=%0d required 0",
                     name, n_viol, n_vld_bad, n_over, n_phase_bad);
        end
    endtask

    task automatic test_single_job();
        run_batch(1, 0, 0, RES, 0, 1'b0);
        check_common("single", 1);
        checks++;
        if (last_rd - first_rd + 1 != int'(JW)) begin
            errors++;
            $display("FAIL single_consecutive: span %0d required %0d", last_rd - first_rd + 1, JW);
        end
    endtask

    task automatic test_empty_toggle();
        run_batch(1, 50, 0, RES, 0, 1'b0);
        check_common("empty", 1);
    endtask

    task automatic test_full_stall();
        run_batch(1, 0, 0, RES, KW + 2, 1'b0);
        check_common("stall", 1);
        checks++;
        if (stall_reads != 0) begin
            errors++;
            $display("FAIL stall_reads: got %0d required 0", stall_reads);
        end
    endtask

    task automatic test_back_to_back();
        run_batch(3, 30, 20, RES, 0, 1'b0);
        check_common("multi", 3);
    endtask

    task automatic test_zero_jobs();
        run_batch(0, 10, 10, RES, 0, 1'b0);
        check_common("zero", 1);
    endtask

    task automatic test_start_busy();
        run_batch(1, 0, 0, RES, 0, 1'b1);
        check_common("busy_start", 1);
    endtask

    task automatic test_timeout();
        int s;
        run_batch(1, 0, 0, 5, 0, 1'b0);
        s = (last_rd + 1 > last_res + 1) ? last_rd + 1 : last_res + 1;
        checks++;
        if (!saw_err || err_cyc != s + int'(TOUT)) begin
            errors++;
            $display("FAIL timeout_cycle: err at %0d (seen=%0d) required %0d", err_cyc, saw_err,
                     s + int'(TOUT));
        end
        checks++;
        if (bus.busy !== 1'b0 || n_jdone != 0 || n_reads != int'(JW)) begin
            errors++;
            $display("FAIL timeout_state: busy=%b job_done=%0d reads=%0d required 0/0/%0d",
                     bus.busy, n_jdone, n_reads, JW);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b1 || bus.in_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: err=%b rd_en=%b required 1/0", bus.err, bus.in_rd_en);
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_jobs = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.shim_clr !== 1'b1) begin
            errors++;
            $display("FAIL start_clears_err: err=%b busy=%b clr=%b required 0/1/1",
                     bus.err, bus.busy, bus.shim_clr);
        end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
    endtask

    task automatic test_abort();
        int rds, jd, k;
        rds = 0;
        jd = 0;
        k = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_jobs = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        while (rds < 2 && k < 50) begin
            #1;
            if (bus.in_rd_en) rds++;
            k++;
            @(negedge clk);
        end
        checks++;
        if (rds < 2) begin
            errors++;
            $display("FAIL abort_setup: reads %0d required 2", rds);
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        #1;
        checks++;
        if (bus.in_rd_en !== 1'b0 || bus.shim_clr !== 1'b1 || bus.job_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle: rd_en=%b clr=%b done=%b required 0/1/0",
                     bus.in_rd_en, bus.shim_clr, bus.job_done);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.phase !== 2'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b phase=%0d err=%b required 0/0/0",
                     bus.busy, bus.phase, bus.err);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.res_vld = 1'b1;
            #1;
            if (bus.job_done || bus.batch_done || bus.in_rd_en) jd++;
        end
        bus.res_vld = 1'b0;
        checks++;
        if (jd != 0) begin
            errors++;
            $display("FAIL abort_no_done: activity %0d required 0", jd);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start = 1'b0;
        bus.num_jobs = '0;
        bus.abort = 1'b0;
        bus.in_empty = 1'b0;
        bus.out_full = 1'b0;
        bus.res_vld = 1'b0;
        test_reset();
        test_single_job();
        test_empty_toggle();
        test_full_stall();
        test_back_to_back();
        test_zero_jobs();
        test_start_busy();
        test_timeout();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
